// File: rtl/top_earlgrey.sv
// Minimal Earl Grey smoke-test top: reset synchronizer, power-up SRAM self-test,
// and a machine timer that starts once the self-test has finished.
module top_earlgrey #(
  parameter int unsigned RAM_DEPTH = 16,
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] LFSR_SEED = 32'hACE12468,
  parameter int unsigned TICK_DIV  = 8
) (
  input logic clk_i,
  input logic rst_ni
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DATA_W-1:0] POLY = 32'h80200003;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [1:0]        rst_sync_q;
  logic              rst_sync_n;
  logic [2:0]        boot_state;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] lfsr;
  logic [DATA_W-1:0] lfsr_next;
  logic              addr_last;
  logic              drain;
  logic              rd_valid;
  logic              rd_fail;
  logic              mismatch;
  logic              selftest_done;
  logic              selftest_pass;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] sram [RAM_DEPTH];
  logic [PW-1:0]     presc;
  logic [63:0]       mtime;
  logic              heartbeat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sync_n = rst_sync_q[1];

  always_comb begin
    lfsr_next = {1'b0, lfsr[DATA_W-1:1]} ^ (lfsr[0] ? POLY : '0);
    addr_last = (addr == AW'(RAM_DEPTH - 1));
    ram_we    = (boot_state == CLEAR) || (boot_state == WRITE);
    ram_wdata = (boot_state == WRITE) ? lfsr : '0;
    rd_fail   = rd_valid && (rdata != lfsr);
  end

  // Storage is deliberately not reset; CLEAR overwrites it on every boot.
  always_ff @(posedge clk_i) begin
    if (ram_we) sram[addr] <= ram_wdata;
    rdata <= sram[addr];
  end

  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      boot_state    <= IDLE;
      addr          <= '0;
      lfsr          <= LFSR_SEED;
      drain         <= 1'b0;
      rd_valid      <= 1'b0;
      mismatch      <= 1'b0;
      selftest_done <= 1'b0;
      selftest_pass <= 1'b0;
    end else begin
      rd_valid <= (boot_state == READ) && !drain;
      case (boot_state)
        IDLE: begin
          boot_state <= CLEAR;
          addr       <= '0;
          lfsr       <= LFSR_SEED;
        end
        CLEAR: begin
          addr <= addr + AW'(1);
          if (addr_last) boot_state <= WRITE;
        end
        WRITE: begin
          addr <= addr + AW'(1);
          if (addr_last) begin
            boot_state <= READ;
            lfsr       <= LFSR_SEED;
          end else begin
            lfsr <= lfsr_next;
          end
        end
        READ: begin
          // Reads return one cycle late, so an extra drain cycle checks the last word.
          if (!drain) begin
            addr <= addr + AW'(1);
            if (addr_last) drain <= 1'b1;
          end
          if (rd_valid) lfsr <= lfsr_next;
          if (rd_fail) mismatch <= 1'b1;
          if (drain) begin
            boot_state    <= DONE;
            selftest_done <= 1'b1;
            selftest_pass <= !(mismatch || rd_fail);
          end
        end
        DONE: ;
        default: boot_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      presc     <= '0;
      mtime     <= '0;
      heartbeat <= 1'b0;
    end else if (boot_state == DONE) begin
      if (presc == PW'(TICK_DIV - 1)) begin
        presc     <= '0;
        mtime     <= mtime + 64'd1;
        heartbeat <= ~heartbeat;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_top_earlgrey.sv
// Directed bench for top_earlgrey: boot sequence timing, SRAM contents,
// timer, mid-run reset, read-fault detection and mtime wrap via probes.
module tb_top_earlgrey;

  logic clk;
  logic rst_n;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          k;
  int          toggles;
  logic        hb_prev;

  typedef struct {
    int          k;
    logic [2:0]  st;
    logic        done;
    logic        pass;
    logic [63:0] mt;
  } vec_t;

  vec_t vecs [12];

  top_earlgrey #(
    .RAM_DEPTH(16),
    .DATA_W   (32),
    .LFSR_SEED(32'hACE12468),
    .TICK_DIV (8)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Advance to cycle index target (cycles counted from rst_sync_n release).
  task automatic run_to(input int target);
    while (k < target) begin
      @(posedge clk);
      #1;
      k++;
      if (dut.heartbeat !== hb_prev) toggles++;
      hb_prev = dut.heartbeat;
    end
  endtask

  // Release reset mid-cycle and step to the edge where rst_sync_n rises.
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("sync_after_1edge", 64'(dut.rst_sync_n), 64'd0);
    @(posedge clk);
    #1;
    check("sync_after_2edge", 64'(dut.rst_sync_n), 64'd1);
    k = 0;
    toggles = 0;
    hb_prev = dut.heartbeat;
  endtask

  task automatic pulse_reset_and_check(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, "_state"}, 64'(dut.boot_state), 64'd0);
    check({tag, "_done"},  64'(dut.selftest_done), 64'd0);
    check({tag, "_pass"},  64'(dut.selftest_pass), 64'd0);
    check({tag, "_mtime"}, dut.mtime, 64'd0);
    check({tag, "_sync"},  64'(dut.rst_sync_n), 64'd0);
    release_reset();
  endtask

  initial begin
    logic [31:0] s;

    vecs[0]  = '{k: 0,   st: 3'd0, done: 1'b0, pass: 1'b0, mt: 64'd0};
    vecs[1]  = '{k: 1,   st: 3'd1, done: 1'b0, pass: 1'b0, mt: 64'd0};
    vecs[2]  = '{k: 16,  st: 3'd1, done: 1'b0, pass: 1'b0, mt: 64'd0};
    vecs[3]  = '{k: 17,  st: 3'd2, done: 1'b0, pass: 1'b0, mt: 64'd0};
    vecs[4]  = '{k: 32,  st: 3'd2, done: 1'b0, pass: 1'b0, mt: 64'd0};
    vecs[5]  = '{k: 33,  st: 3'd3, done: 1'b0, pass: 1'b0, mt: 64'd0};
    vecs[6]  = '{k: 49,  st: 3'd3, done: 1'b0, pass: 1'b0, mt: 64'd0};
    vecs[7]  = '{k: 50,  st: 3'd4, done: 1'b1, pass: 1'b1, mt: 64'd0};
    vecs[8]  = '{k: 57,  st: 3'd4, done: 1'b1, pass: 1'b1, mt: 64'd0};
    vecs[9]  = '{k: 58,  st: 3'd4, done: 1'b1, pass: 1'b1, mt: 64'd1};
    vecs[10] = '{k: 449, st: 3'd4, done: 1'b1, pass: 1'b1, mt: 64'd49};
    vecs[11] = '{k: 450, st: 3'd4, done: 1'b1, pass: 1'b1, mt: 64'd50};

    rst_n = 1'b0;
    k = 0;
    toggles = 0;
    hb_prev = 1'b0;
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("por_sync_edge1", 64'(dut.rst_sync_n), 64'd0);
    check("por_state_edge1", 64'(dut.boot_state), 64'd0);
    @(posedge clk);
    #1;
    check("por_sync_edge2", 64'(dut.rst_sync_n), 64'd1);
    hb_prev = dut.heartbeat;

    // Power-on sequence against the timing table
    for (int i = 0; i < 12; i++) begin
      run_to(vecs[i].k);
      check($sformatf("state@%0d", vecs[i].k), 64'(dut.boot_state), 64'(vecs[i].st));
      check($sformatf("done@%0d",  vecs[i].k), 64'(dut.selftest_done), 64'(vecs[i].done));
      check($sformatf("pass@%0d",  vecs[i].k), 64'(dut.selftest_pass), 64'(vecs[i].pass));
      check($sformatf("mtime@%0d", vecs[i].k), dut.mtime, vecs[i].mt);
    end
    check("hb_toggles", 64'(toggles), 64'd50);
    check("hb_level", 64'(dut.heartbeat), 64'd0);

    // SRAM holds the seeded LFSR sequence
    s = 32'hACE12468;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("sram[%0d]", i), 64'(dut.sram[i]), 64'(s));
      s = lfsr_step(s);
    end

    // mtime wrap: tick just happened at k=450, next one at k=458
    @(negedge clk);
    dut.mtime = 64'hFFFF_FFFF_FFFF_FFFF;
    run_to(457);
    check("wrap_before", dut.mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    run_to(458);
    check("wrap_after", dut.mtime, 64'd0);
    run_to(466);
    check("wrap_next", dut.mtime, 64'd1);

    // Reset from DONE with a running timer
    pulse_reset_and_check("rst_done");
    check("rerun_state0", 64'(dut.boot_state), 64'd0);

    // Reset pulse during WRITE, then a full clean rerun
    run_to(20);
    check("midrun_in_write", 64'(dut.boot_state), 64'd2);
    pulse_reset_and_check("rst_write");
    run_to(49);
    check("rerun_done49", 64'(dut.selftest_done), 64'd0);
    run_to(50);
    check("rerun_state50", 64'(dut.boot_state), 64'd4);
    check("rerun_done50", 64'(dut.selftest_done), 64'd1);
    check("rerun_pass50", 64'(dut.selftest_pass), 64'd1);
    check("rerun_mtime50", dut.mtime, 64'd0);

    // Corrupt word 5 during READ before it is read back
    pulse_reset_and_check("rst_fault");
    run_to(35);
    check("fault_in_read", 64'(dut.boot_state), 64'd3);
    dut.sram[5] = 32'h0;
    run_to(49);
    check("fault_done49", 64'(dut.selftest_done), 64'd0);
    run_to(50);
    check("fault_state50", 64'(dut.boot_state), 64'd4);
    check("fault_done50", 64'(dut.selftest_done), 64'd1);
    check("fault_pass50", 64'(dut.selftest_pass), 64'd0);
    run_to(60);
    check("fault_pass_held", 64'(dut.selftest_pass), 64'd0);
    check("fault_mtime60", dut.mtime, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
